// File: rtl/pattern_detector_par.sv
// Parallel-word pattern detector: masked compare of each qualified word against a
// programmable pattern, N consecutive hits to declare a match, saturating entry count.
module pattern_detector_par #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HOLD_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_load,
    input  logic [WIDTH-1:0]  cfg_pattern,
    input  logic [WIDTH-1:0]  cfg_mask,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic              clr_count,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  x,
    output logic              z,
    output logic              rise,
    output logic [CNT_W-1:0]  match_count
);

    typedef enum logic [1:0] {
        NOMATCH = 2'd0,
        ARMING  = 2'd1,
        MATCH   = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [HOLD_W-1:0]   run_q,     run_d;
    logic [WIDTH-1:0]    pattern_q, pattern_d;
    logic [WIDTH-1:0]    mask_q,    mask_d;
    logic [HOLD_W-1:0]   hold_q,    hold_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                rise_q,    rise_d;

    logic                hit;
    logic                miss;
    logic                entry;
    logic [HOLD_W-1:0]   run_inc;

    assign hit     = in_valid && (((x ^ pattern_q) & mask_q) == '0);
    assign miss    = in_valid && !hit;
    assign run_inc = run_q + HOLD_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= NOMATCH;
            run_q     <= '0;
            pattern_q <= '0;
            mask_q    <= '1;
            hold_q    <= HOLD_W'(1);
            count_q   <= '0;
            rise_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            pattern_q <= pattern_d;
            mask_q    <= mask_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            rise_q    <= rise_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        pattern_d = pattern_q;
        mask_d    = mask_q;
        hold_d    = hold_q;

        if (cfg_load) begin
            pattern_d = cfg_pattern;
            mask_d    = cfg_mask;
            // hold is stored already clamped, so the FSM never sees zero
            hold_d    = (cfg_hold == '0) ? HOLD_W'(1) : cfg_hold;
            state_d   = NOMATCH;
            run_d     = '0;
        end else begin
            unique case (state_q)
                NOMATCH: begin
                    if (hit) begin
                        if (hold_q == HOLD_W'(1)) begin
                            state_d = MATCH;
                        end else begin
                            state_d = ARMING;
                            run_d   = HOLD_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (hit) begin
                        if (run_inc == hold_q) begin
                            state_d = MATCH;
                            run_d   = '0;
                        end else begin
                            run_d   = run_inc;
                        end
                    end else if (miss) begin
                        state_d = NOMATCH;
                        run_d   = '0;
                    end
                end
                MATCH: begin
                    if (miss) begin
                        state_d = NOMATCH;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = NOMATCH;
                    run_d   = '0;
                end
            endcase
        end
    end

    // Entry detection and the saturating event counter; an entry outranks a clear
    always_comb begin
        entry   = (state_d == MATCH) && (state_q != MATCH);
        rise_d  = entry;
        count_d = count_q;
        if (entry) begin
            if (clr_count) begin
                count_d = CNT_W'(1);
            end else if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (clr_count) begin
            count_d = '0;
        end
    end

    // Output logic
    always_comb begin
        z           = (state_q == MATCH);
        rise        = rise_q;
        match_count = count_q;
    end

endmodule

// File: tb/tb_pattern_detector_par.sv
// Directed bench for pattern_detector_par with hand-computed expectations;
// a 2-bit event counter makes saturation reachable in a few entries.
module tb_pattern_detector_par;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned HOLD_W = 4;
    localparam int unsigned CNT_W  = 2;

    logic              clk;
    logic              rst;
    logic              cfg_load;
    logic [WIDTH-1:0]  cfg_pattern;
    logic [WIDTH-1:0]  cfg_mask;
    logic [HOLD_W-1:0] cfg_hold;
    logic              clr_count;
    logic              in_valid;
    logic [WIDTH-1:0]  x;
    logic              z;
    logic              rise;
    logic [CNT_W-1:0]  match_count;

    int unsigned n_checks;
    int unsigned n_errors;

    pattern_detector_par #(
        .WIDTH  (WIDTH),
        .HOLD_W (HOLD_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_hold    (cfg_hold),
        .clr_count   (clr_count),
        .in_valid    (in_valid),
        .x           (x),
        .z           (z),
        .rise        (rise),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one edge; inputs are then changed / outputs sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic v, input logic [WIDTH-1:0] xv);
        in_valid = v;
        x        = xv;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] m, input logic [HOLD_W-1:0] h);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_hold    = h;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic clear();
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic ez, input logic er, input logic [CNT_W-1:0] ec);
        check_eq({tag, ".z"},     32'(z),           32'(ez));
        check_eq({tag, ".rise"},  32'(rise),        32'(er));
        check_eq({tag, ".count"}, 32'(match_count), 32'(ec));
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst         = 1'b1;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_mask    = '0;
        cfg_hold    = '0;
        clr_count   = 1'b0;
        in_valid    = 1'b0;
        x           = '0;

        tick();
        tick();
        rst = 1'b0;
        expect_out("reset", 1'b0, 1'b0, 2'd0);

        // Reset config is pattern 0, mask all ones, hold 1
        cycle(1'b1, 16'h0000);
        expect_out("rstcfg_hit", 1'b1, 1'b1, 2'd1);
        cycle(1'b1, 16'h0001);
        expect_out("rstcfg_miss", 1'b0, 1'b0, 2'd1);
        clear();
        expect_out("clr_only", 1'b0, 1'b0, 2'd0);

        // Basic match
        load(16'hA5C3, 16'hFFFF, 4'd1);
        expect_out("basic_load", 1'b0, 1'b0, 2'd0);
        cycle(1'b1, 16'hA5C3);
        expect_out("basic_hit", 1'b1, 1'b1, 2'd1);
        cycle(1'b0, 16'h0000);
        expect_out("basic_idle", 1'b1, 1'b0, 2'd1);
        cycle(1'b1, 16'h0000);
        expect_out("basic_miss", 1'b0, 1'b0, 2'd1);

        // Don't-care mask
        load(16'h3C00, 16'hFF00, 4'd1);
        cycle(1'b1, 16'h3CFF);
        expect_out("mask_hit", 1'b1, 1'b1, 2'd2);
        cycle(1'b1, 16'h3DFF);
        expect_out("mask_miss", 1'b0, 1'b0, 2'd2);
        clear();

        // hold=3 with idle gaps inside the run
        load(16'h3C00, 16'hFF00, 4'd3);
        cycle(1'b1, 16'h3C00);
        expect_out("gap_h1", 1'b0, 1'b0, 2'd0);
        cycle(1'b0, 16'h3C00);
        cycle(1'b1, 16'h3C11);
        expect_out("gap_h2", 1'b0, 1'b0, 2'd0);
        cycle(1'b0, 16'h0000);
        expect_out("gap_idle", 1'b0, 1'b0, 2'd0);
        cycle(1'b1, 16'h3C22);
        expect_out("gap_h3", 1'b1, 1'b1, 2'd1);
        cycle(1'b1, 16'h0000);
        expect_out("gap_miss", 1'b0, 1'b0, 2'd1);

        // hit, hit, miss, hit, hit never reaches 3; a further hit does
        cycle(1'b1, 16'h3C00);
        cycle(1'b1, 16'h3C00);
        expect_out("brk_hh", 1'b0, 1'b0, 2'd1);
        cycle(1'b1, 16'h1200);
        cycle(1'b1, 16'h3C00);
        cycle(1'b1, 16'h3C00);
        expect_out("brk_hhmhh", 1'b0, 1'b0, 2'd1);
        cycle(1'b1, 16'h3C00);
        expect_out("brk_third", 1'b1, 1'b1, 2'd2);
        cycle(1'b1, 16'h0000);
        clear();

        // hold=0 behaves as 1; continuous hits pulse once
        load(16'hA5C3, 16'hFFFF, 4'd0);
        cycle(1'b1, 16'hA5C3);
        expect_out("cont_1", 1'b1, 1'b1, 2'd1);
        for (int i = 2; i <= 5; i++) begin
            cycle(1'b1, 16'hA5C3);
            expect_out($sformatf("cont_%0d", i), 1'b1, 1'b0, 2'd1);
        end

        // cfg_load while in MATCH together with a hitting word
        cfg_load = 1'b1;
        in_valid = 1'b1;
        x        = 16'hA5C3;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        expect_out("reload_match", 1'b0, 1'b0, 2'd1);
        cycle(1'b0, 16'h0000);
        expect_out("reload_idle", 1'b0, 1'b0, 2'd1);

        // Word sampled with cfg_load does not start a hold=2 run
        cfg_load = 1'b1;
        cfg_hold = 4'd2;
        in_valid = 1'b1;
        x        = 16'hA5C3;
        tick();
        cfg_load = 1'b0;
        in_valid = 1'b0;
        cycle(1'b1, 16'hA5C3);
        expect_out("ign_h1", 1'b0, 1'b0, 2'd1);
        cycle(1'b1, 16'hA5C3);
        expect_out("ign_h2", 1'b1, 1'b1, 2'd2);

        // Reset while in MATCH
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_match", 1'b0, 1'b0, 2'd0);

        // Saturation at 3 with rise still pulsing
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b1, 16'h0000);
            expect_out($sformatf("sat_%0d", i), 1'b1, 1'b1, (i >= 3) ? 2'd3 : 2'(i));
            cycle(1'b1, 16'hFFFF);
        end

        // Clear on the same edge as an entry leaves a count of 1
        clr_count = 1'b1;
        cycle(1'b1, 16'h0000);
        clr_count = 1'b0;
        expect_out("clr_entry", 1'b1, 1'b1, 2'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pattern_detector_par.md
# pattern_detector_par

Parametrised parallel-word pattern detector: each qualified input word is compared against a programmable pattern under a care-mask, and the block requires a programmable number of consecutive hits before declaring a match. It counts match events and emits a level flag plus an entry pulse. It is the next generation of the fixed 16-bit, two-state detector and sits in the same datapath slot: word in, match flag out, all in one clock domain.

## Interface
- WIDTH, 16, compared word width in bits (≥1)
- HOLD_W, 4, width of the consecutive-hit requirement field
- CNT_W, 8, width of the match-event counter

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cfg_load  in  1  load cfg_pattern/cfg_mask/cfg_hold this edge; restarts detection
- cfg_pattern  in  WIDTH  pattern to match
- cfg_mask  in  WIDTH  care-mask; bit=1 compares, bit=0 is don't-care
- cfg_hold  in  HOLD_W  consecutive valid hits required; 0 is treated as 1
- clr_count  in  1  clear match_count
- in_valid  in  1  x is a qualified word this cycle
- x  in  WIDTH  input word
- z  out  1  high while in MATCH state
- rise  out  1  one-cycle pulse on each NOMATCH/ARMING→MATCH entry
- match_count  out  CNT_W  saturating count of MATCH entries

## Operation
- Hit = in_valid & (((x ^ pattern) & mask) == 0). Miss = in_valid & !hit. Idle cycles (in_valid=0) change nothing: state, run counter, and outputs hold.
- Registers: pattern, mask, and hold (eff_hold = max(cfg_hold, 1)); run counter (HOLD_W bits); state; match_count.
- The FSM has 3 states:
  - NOMATCH
    - hit: go to MATCH if eff_hold==1, else go to ARMING with run=1.
    - miss: stay.
  - ARMING
    - hit: run+1. When run+1 == eff_hold, go to MATCH and set run=0.
    - miss: go to NOMATCH with run=0.
  - MATCH
    - hit: stay. Overlapping/continuous matches do not re-pulse.
    - miss: go to NOMATCH with run=0.
- z = (state==MATCH), driven from the state register.
- rise is registered. It is 1 in the cycle after the edge on which the FSM transitions into MATCH.
- match_count increments on each MATCH entry and saturates at 2^CNT_W−1.
- cfg_load:
  - Captures all three config fields.
  - Forces state to NOMATCH and run to 0.
  - The word presented in the same cycle is ignored.
  - z and rise are 0 the following cycle.
  - match_count is unaffected.
- clr_count sets match_count to 0. If a MATCH entry occurs on the same edge, match_count becomes 1 (the entry wins over clear).
- Priority: rst > cfg_load > detection. clr_count is independent of cfg_load.

## Timing
- Reset values (applied on the rst edge):
  - state NOMATCH, run 0
  - z 0, rise 0, match_count 0
  - pattern all 0, mask all 1, hold 1
- Latency: the word sampled at edge k that completes the hit requirement produces z=1 and rise=1 in the cycle after edge k.
  - With eff_hold=N and back-to-back valid hits starting at edge k, z rises after edge k+N−1.
- z falls in the cycle after the edge that samples a miss.
- Idle gaps inside an ARMING run do not break the run. Only a miss breaks it.
- rst or cfg_load asserted mid-ARMING or in MATCH discards the run. z drops the next cycle with no rise pulse.
- cfg_hold changes take effect only through cfg_load.
- run counter never exceeds eff_hold−1, so no wrap is possible. The maximum programmable hold is 2^HOLD_W−1.
- Counter saturated plus a new entry: match_count stays at its maximum, and rise still pulses.

## Test plan
- **Reset and basic match.** Apply reset, then cfg_load with pattern=16'hA5C3, mask=16'hFFFF, hold=1, then one valid x=16'hA5C3 → z=1 and rise=1 for one cycle, match_count=1. Next valid x=16'h0000 → z=0.
- **Don't-care mask.** mask=16'hFF00, pattern=16'h3C00. Valid x=16'h3CFF → hit. Valid x=16'h3DFF → miss.
- **Consecutive hits with gaps.** hold=3; stimulus hit, idle, hit, idle, hit → z rises only after the 3rd hit. Sequence hit, hit, miss, hit, hit → z stays 0.
- **Continuous match.** hold=1; 5 consecutive hits → z high throughout, rise pulses once, match_count=1.
- **Config reload mid-operation.** While in MATCH, assert cfg_load → z=0 the next cycle, with no rise pulse. Assert cfg_load during a hit cycle → that word is ignored.
- **Counter clear and saturation.** CNT_W=2: drive 4 separate match entries → match_count=3. Assert clr_count together with a 5th entry → match_count=1.
